// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter for the single register-file write port
// Optional build macro: WB_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module regfile_wb_arbiter #(
   parameter int N_REQ = 3,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*AW-1:0] req_reg,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    req_ready,
   input  logic                wb_hold,
   output logic                rf_regwrite,
   output logic [AW-1:0]       rf_writereg,
   output logic [DW-1:0]       rf_writedata,
   output logic [CNT_W-1:0]    conflict_cnt
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] grant;
   logic [AW-1:0]    sel_reg;
   logic [DW-1:0]    sel_data;
   logic             contention;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gnt_idx;
`endif

   // Pick one valid requester: first valid index starting at the search origin.
   always_comb begin : grant_search
      int  idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      gnt_idx = '0;
`endif
      for (int k = 0; k < N_REQ; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
`else
         idx = k;
`endif
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
            gnt_idx    = PW'(idx);
`endif
         end
      end
   end

   // Grants are suppressed during hold and while reset is asserted.
   assign req_ready = (wb_hold || !rst_n) ? '0 : grant;

   // Two or more simultaneous requesters: (v & (v-1)) is nonzero iff popcount >= 2.
   assign contention = ((req_valid & (req_valid - 1'b1)) != '0);

   // Mux the granted requester's destination and data into the output stage.
   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_reg  = req_reg[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Output stage: load accepted writes, squash $0 writes, idle otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_regwrite  <= 1'b0;
         rf_writereg  <= '0;
         rf_writedata <= '0;
      end else if (req_ready != '0) begin
         rf_regwrite  <= (sel_reg != '0);
         rf_writereg  <= sel_reg;
         rf_writedata <= sel_data;
      end else begin
         rf_regwrite  <= 1'b0;
      end
   end

   // Saturating count of unheld cycles with contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (contention && !wb_hold && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

`ifdef WB_ARB_ROUND_ROBIN_EN
   // Advance the round-robin origin just past each accepted requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (req_ready != '0) begin
         if (gnt_idx == PW'(N_REQ - 1)) rr_ptr <= '0;
         else                           rr_ptr <= gnt_idx + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_reg;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wb_hold;
   logic            rf_regwrite;
   logic [AW-1:0]   rf_writereg;
   logic [DW-1:0]   rf_writedata;
   logic [CW-1:0]   conflict_cnt;

   logic          v [N];
   logic [AW-1:0] r [N];
   logic [DW-1:0] d [N];

   logic [AW+DW:0] exp_q [$];
   int m_ptr;
   int m_cnt;
   int n_assert;
   int n_fail;

   regfile_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_reg      (req_reg),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .wb_hold      (wb_hold),
      .rf_regwrite  (rf_regwrite),
      .rf_writereg  (rf_writereg),
      .rf_writedata (rf_writedata),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_valid = '0;
      req_reg   = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = v[i];
         req_reg[i*AW +: AW]  = r[i];
         req_data[i*DW +: DW] = d[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] model_grant();
      logic [N-1:0] g;
      int idx;
      g = '0;
      if (wb_hold) return g;
      for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
         idx = (m_ptr + k) % N;
`else
         idx = k;
`endif
         if (v[idx] && g == '0) g[idx] = 1'b1;
      end
      return g;
   endfunction

   // One cycle: check grant, push expected write, cross the edge, check output stage.
   task automatic step(input bit refill);
      logic [N-1:0] eg;
      logic [AW+DW:0] e;
      int gi;
      int nv;
      #1;
      eg = model_grant();
      chk("ready", 64'(req_ready), 64'(eg));
      gi = -1;
      nv = 0;
      for (int i = 0; i < N; i++) begin
         if (eg[i]) gi = i;
         if (v[i]) nv++;
      end
      if (gi >= 0) begin
         exp_q.push_back({r[gi] != '0, r[gi], d[gi]});
         m_ptr = (gi + 1) % N;
      end
      if (!wb_hold && nv >= 2 && m_cnt < 15) m_cnt++;
      @(posedge clk);
      #1;
      if (gi >= 0) begin
         if (refill) begin
            r[gi] = AW'($urandom_range(1, 31));
            d[gi] = $urandom;
         end else begin
            v[gi] = 1'b0;
         end
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rf_regwrite", 64'(rf_regwrite), 64'(e[AW+DW]));
         chk("rf_writereg", 64'(rf_writereg), 64'(e[AW+DW-1:DW]));
         chk("rf_writedata", 64'(rf_writedata), 64'(e[DW-1:0]));
      end else begin
         chk("rf_regwrite_idle", 64'(rf_regwrite), 64'd0);
      end
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      wb_hold  = 1'b0;
      rst_n    = 1'b0;
      m_ptr    = 0;
      m_cnt    = 0;
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b1;
         r[i] = AW'(i + 1);
         d[i] = DW'(i);
      end
      // Reset with every requester valid
      #3;
      chk("reset_ready", 64'(req_ready), 64'd0);
      chk("reset_regwrite", 64'(rf_regwrite), 64'd0);
      chk("reset_writereg", 64'(rf_writereg), 64'd0);
      chk("reset_writedata", 64'(rf_writedata), 64'd0);
      chk("reset_cnt", 64'(conflict_cnt), 64'd0);
      do_reset();

      // Single source
      v[1] = 1'b1; r[1] = 5'd7; d[1] = 32'hDEADBEEF;
      step(0);
      step(0);

      // Contention for six cycles
      do_reset();
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b1;
         r[i] = AW'(10 + i);
         d[i] = DW'(32'h100 + i);
      end
      for (int c = 0; c < 6; c++) step(1);
      chk("contention_cnt6", 64'(conflict_cnt), 64'd6);
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      step(0);

      // $0 write is consumed but not committed
      v[0] = 1'b1; r[0] = 5'd0; d[0] = 32'h55;
      step(0);
      step(0);

      // Same destination from two sources back to back
      v[0] = 1'b1; r[0] = 5'd9; d[0] = 32'hAAAA0000;
      step(0);
      v[1] = 1'b1; r[1] = 5'd9; d[1] = 32'hBBBB1111;
      step(0);
      step(0);

      // Hold raised right after an acceptance
      v[0] = 1'b1; r[0] = 5'd3; d[0] = 32'h12345678;
      step(0);
      wb_hold = 1'b1;
      v[2] = 1'b1; r[2] = 5'd4; d[2] = 32'hCAFEF00D;
      v[1] = 1'b1; r[1] = 5'd5; d[1] = 32'h0BADF00D;
      #1;
      chk("hold_inflight_commit", 64'(rf_regwrite), 64'd1);
      step(0);
      step(0);
      wb_hold = 1'b0;
      step(0);
      step(0);
      step(0);

      // Reset mid-operation drops a pending output-stage write
      v[2] = 1'b1; r[2] = 5'd6; d[2] = 32'h77;
      step(0);
      rst_n = 1'b0;
      #1;
      chk("midreset_regwrite", 64'(rf_regwrite), 64'd0);
      chk("midreset_ready", 64'(req_ready), 64'd0);
      do_reset();

      // Saturation of the 4-bit contention counter
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b1;
         r[i] = AW'(20 + i);
         d[i] = $urandom;
      end
      for (int c = 0; c < 20; c++) step(1);
      chk("sat_cnt", 64'(conflict_cnt), 64'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
